unix_time_to_calendar: RTL and testbench

//  Downstream of the network time-fetch block. Its one-cycle completion pulse and
//  32-bit seconds value (Unix epoch seconds, already offset to local time) drive this

---
 rtl/unix_time_to_calendar.sv | 197 +++++++++++++++++++
 tb/tb_unix_time_to_calendar.sv | 139 +++++++++++++
 2 files changed

// File: rtl/unix_time_to_calendar.sv
// unix_time_to_calendar: iterative converter from local Unix seconds to calendar fields.
// Latency is data dependent, at most about 270 cycles. A start that arrives while busy is dropped, not queued.
// Define CAL_BCD_EN for packed-BCD fields, which adds the CONV state. Without it the fields are plain binary.
module unix_time_to_calendar (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] sec_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] year,
    output logic [7:0]  month,
    output logic [7:0]  day,
    output logic [7:0]  hour,
    output logic [7:0]  minute,
    output logic [7:0]  second,
    output logic [2:0]  weekday
);
    localparam int EPOCH_YEAR = 1970;
    localparam int EPOCH_WDAY = 4;
    localparam logic [17:0] SEC_PER_DAY = 18'd86400;
`ifdef CAL_BCD_EN
    localparam logic [15:0] YEAR_RST = 16'h1970;
`else
    localparam logic [15:0] YEAR_RST = 16'd1970;
`endif

    typedef enum logic [2:0] {IDLE, DIV_DAY, HMS, YEAR, MONTH, CONV, DONE} state_t;

    state_t      state;
    logic [31:0] quo;
    logic [17:0] rem;
    logic [4:0]  bit_cnt;
    logic        hms_min;
    logic [4:0]  hr;
    logic [5:0]  mn;
    logic [15:0] days;
    logic [11:0] yr;
    logic [3:0]  mon;
    logic [2:0]  wd;
`ifdef CAL_BCD_EN
    logic [4:0]  dy;
`endif

    logic [17:0] rem_sh;
    logic        leap;
    logic [8:0]  ylen;
    logic [4:0]  mlen;

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
        case (m)
            4'd2:                    return lp ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            default:                 return 5'd31;
        endcase
    endfunction

`ifdef CAL_BCD_EN
    function automatic logic [7:0] bcd2(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction
`endif

    // The leap rule is only exact over 1970..2106. That span covers every 32-bit input.
    always_comb begin
        rem_sh = {rem[16:0], quo[31]};
        leap   = (yr[1:0] == 2'b00) && (yr != 12'd2100);
        ylen   = leap ? 9'd366 : 9'd365;
        mlen   = month_len(mon, leap);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            quo     <= '0;
            rem     <= '0;
            bit_cnt <= '0;
            hms_min <= 1'b0;
            hr      <= '0;
            mn      <= '0;
            days    <= '0;
            yr      <= 12'(EPOCH_YEAR);
            mon     <= 4'd1;
            wd      <= 3'(EPOCH_WDAY);
`ifdef CAL_BCD_EN
            dy      <= 5'd1;
`endif
            year    <= YEAR_RST;
            month   <= 8'h01;
            day     <= 8'h01;
            hour    <= '0;
            minute  <= '0;
            second  <= '0;
            weekday <= 3'(EPOCH_WDAY);
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    quo     <= sec_in;
                    rem     <= '0;
                    bit_cnt <= '0;
                    busy    <= 1'b1;
                    state   <= DIV_DAY;
                end
                DIV_DAY: begin
                    if (rem_sh >= SEC_PER_DAY) begin
                        rem <= rem_sh - SEC_PER_DAY;
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        quo <= {quo[30:0], 1'b0};
                    end
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        state   <= HMS;
                        hms_min <= 1'b0;
                        hr      <= '0;
                        mn      <= '0;
                    end
                end
                HMS: begin
                    // The quotient is stable throughout HMS, so days and weekday settle here.
                    days <= quo[15:0];
                    wd   <= 3'((17'(quo[15:0]) + 17'(EPOCH_WDAY)) % 17'd7);
                    if (!hms_min) begin
                        if (rem >= 18'd3600) begin
                            rem <= rem - 18'd3600;
                            hr  <= hr + 5'd1;
                        end else begin
                            hms_min <= 1'b1;
                        end
                    end else if (rem >= 18'd60) begin
                        rem <= rem - 18'd60;
                        mn  <= mn + 6'd1;
                    end else begin
                        state <= YEAR;
                        yr    <= 12'(EPOCH_YEAR);
                    end
                end
                YEAR: begin
                    if (days >= {7'd0, ylen}) begin
                        days <= days - {7'd0, ylen};
                        yr   <= yr + 12'd1;
                    end else begin
                        state <= MONTH;
                        mon   <= 4'd1;
                    end
                end
                MONTH: begin
                    if (days >= {11'd0, mlen}) begin
                        days <= days - {11'd0, mlen};
                        mon  <= mon + 4'd1;
                    end else begin
`ifdef CAL_BCD_EN
                        dy    <= days[4:0] + 5'd1;
                        state <= CONV;
`else
                        year    <= {4'd0, yr};
                        month   <= {4'd0, mon};
                        day     <= {3'd0, days[4:0] + 5'd1};
                        hour    <= {3'd0, hr};
                        minute  <= {2'd0, mn};
                        second  <= {2'd0, rem[5:0]};
                        weekday <= wd;
                        done    <= 1'b1;
                        state   <= DONE;
`endif
                    end
                end
`ifdef CAL_BCD_EN
                CONV: begin
                    year    <= {4'(yr / 12'd1000), 4'((yr / 12'd100) % 12'd10),
                                4'((yr / 12'd10) % 12'd10), 4'(yr % 12'd10)};
                    month   <= bcd2({3'd0, mon});
                    day     <= bcd2({2'd0, dy});
                    hour    <= bcd2({2'd0, hr});
                    minute  <= bcd2({1'b0, mn});
                    second  <= bcd2({1'b0, rem[5:0]});
                    weekday <= wd;
                    done    <= 1'b1;
                    state   <= DONE;
                end
`endif
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_unix_time_to_calendar.sv
// Directed bench for unix_time_to_calendar. It checks field encoding for both builds, depending on CAL_BCD_EN.
module tb_unix_time_to_calendar;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] sec_in;
    logic        busy, done;
    logic [15:0] year;
    logic [7:0]  month, day, hour, minute, second;
    logic [2:0]  weekday;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    unix_time_to_calendar dut (
        .clk(clk), .reset_n(reset_n), .start(start), .sec_in(sec_in),
        .busy(busy), .done(done), .year(year), .month(month), .day(day),
        .hour(hour), .minute(minute), .second(second), .weekday(weekday)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done) done_cnt++;

    function automatic logic [31:0] enc(input int v);
`ifdef CAL_BCD_EN
        return 32'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
`else
        return 32'(v);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fields(input string tag, input int y, input int mo, input int d,
                                input int h, input int mi, input int s, input int wd);
        check({tag, " year"},    {16'd0, year},   enc(y));
        check({tag, " month"},   {24'd0, month},  enc(mo));
        check({tag, " day"},     {24'd0, day},    enc(d));
        check({tag, " hour"},    {24'd0, hour},   enc(h));
        check({tag, " minute"},  {24'd0, minute}, enc(mi));
        check({tag, " second"},  {24'd0, second}, enc(s));
        check({tag, " weekday"}, {29'd0, weekday}, 32'(wd));
    endtask

    // Waits up to 300 cycles for done, sampling on falling edges.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, " done within bound"}, {31'd0, done}, 32'd1);
    endtask

    task automatic convert(input string tag, input logic [31:0] s, input int y, input int mo,
                           input int d, input int h, input int mi, input int sc, input int wd);
        start  = 1'b1;
        sec_in = s;
        @(negedge clk);
        start  = 1'b0;
        sec_in = $urandom;
        check({tag, " busy after accept"}, {31'd0, busy}, 32'd1);
        wait_done(tag);
        check_fields(tag, y, mo, d, h, mi, sc, wd);
        check({tag, " busy in done cycle"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        check({tag, " done single pulse"}, {31'd0, done}, 32'd0);
        check({tag, " busy falls"}, {31'd0, busy}, 32'd0);
        check_fields({tag, " hold"}, y, mo, d, h, mi, sc, wd);
    endtask

    initial begin
        int n0;
        reset_n = 1'b0;
        start   = 1'b0;
        sec_in  = '0;
        repeat (3) @(negedge clk);
        check_fields("reset", 1970, 1, 1, 0, 0, 0, 4);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        convert("epoch",    32'd0,          1970, 1, 1, 0, 0, 0, 4);
        convert("y2k_leap", 32'd951782400,  2000, 2, 29, 0, 0, 0, 2);
        convert("y2024",    32'd1725896265, 2024, 9, 9, 15, 37, 45, 1);
        convert("feb2100",  32'd4107542399, 2100, 2, 28, 23, 59, 59, 0);
        convert("mar2100",  32'd4107542400, 2100, 3, 1, 0, 0, 0, 1);
        convert("max",      32'hFFFFFFFF,   2106, 2, 7, 6, 28, 15, 0);
        n0 = done_cnt;
        repeat (50) @(negedge clk);
        check("max no extra done", 32'(done_cnt - n0), 32'd0);

        // A second start while busy must be ignored.
        n0 = done_cnt;
        start  = 1'b1;
        sec_in = 32'd1725896265;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start  = 1'b1;
        sec_in = 32'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore2nd");
        check_fields("ignore2nd", 2024, 9, 9, 15, 37, 45, 1);
        repeat (300) @(negedge clk);
        check("ignore2nd one done", 32'(done_cnt - n0), 32'd1);

        // Reset in the middle of a conversion.
        n0 = done_cnt;
        start  = 1'b1;
        sec_in = 32'd951782400;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check_fields("midreset", 1970, 1, 1, 0, 0, 0, 4);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        check("midreset no done", 32'(done_cnt - n0), 32'd0);
        convert("after_reset", 32'd4107542399, 2100, 2, 28, 23, 59, 59, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
